// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 16;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int clog2_p1(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) begin
            w++;
        end
        return w;
    endfunction

    function automatic int popcount(input logic [MAX_PIPE_DEPTH-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_PIPE_DEPTH; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_cell.sv
// One pipeline stage: data plus valid, with load-from-predecessor and flush.
module pipe_reg_cell
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             valid_next
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             valid_reg;

    // Flush is applied after the move so it also kills a freshly loaded entry.
    always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        if (load) begin
            data_next  = prev_data;
            valid_next = prev_valid;
        end
        if (flush) begin
            valid_next = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                data_next = RESET_VAL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= RESET_VAL;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-deep pipeline register with per-stage valid, global stall,
// per-stage flush and optional bubble collapse while stalled.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 1,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b0,
    parameter bit               COLLAPSE       = 1'b0,
    localparam int              OCC_W          = clog2_p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_bar,
    input  logic [DEPTH-1:0] flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [DEPTH-1:0] stage_valid,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0]          data [DEPTH];
    logic [DEPTH-1:0]          valid;
    logic [DEPTH-1:0]          valid_next;
    logic [DEPTH-1:0]          advance;
    logic                      bubble_seen;
    logic [MAX_PIPE_DEPTH-1:0] valid_next_ext;
    logic [OCC_W-1:0]          occupancy_reg;

    // Scanning from the output end, a stage advances while stalled only if
    // some stage at or downstream of it is empty (i.e. it lies in 0..h).
    always_comb begin
        bubble_seen = 1'b0;
        advance     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            bubble_seen = bubble_seen | ~valid[i];
            advance[i]  = ~enable_bar | (COLLAPSE ? bubble_seen : 1'b0);
        end
    end

    assign in_ready = advance[0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] prev_data;
            logic             prev_valid;

            if (gi == 0) begin : g_head
                assign prev_data  = in;
                assign prev_valid = in_valid;
            end else begin : g_body
                assign prev_data  = data[gi-1];
                assign prev_valid = valid[gi-1];
            end

            pipe_reg_cell #(
                .WIDTH          (WIDTH),
                .RESET_VAL      (RESET_VAL),
                .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .load       (advance[gi]),
                .flush      (flush[gi]),
                .prev_data  (prev_data),
                .prev_valid (prev_valid),
                .data       (data[gi]),
                .valid      (valid[gi]),
                .valid_next (valid_next[gi])
            );
        end
    endgenerate

    always_comb begin
        valid_next_ext            = '0;
        valid_next_ext[DEPTH-1:0] = valid_next;
    end

    // Counted from the next-state valids so it tracks stage_valid exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= OCC_W'(popcount(valid_next_ext));
        end
    end

    assign out         = data[DEPTH-1];
    assign out_valid   = valid[DEPTH-1];
    assign stage_valid = valid;
    assign occupancy   = occupancy_reg;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: three configurations driven in lockstep.
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_bar;
    logic       in_valid;
    logic [2:0] flush;
    logic [7:0] din;

    logic       u0_ready, u0_ov;
    logic [7:0] u0_out;
    logic [2:0] u0_sv;
    logic [1:0] u0_occ;
    logic       u1_ready, u1_ov;
    logic [7:0] u1_out;
    logic [2:0] u1_sv;
    logic [1:0] u1_occ;
    logic       u2_ready, u2_ov;
    logic [7:0] u2_out;
    logic [0:0] u2_sv;
    logic [0:0] u2_occ;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // u0: plain stall, no clear
    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .CLEAR_ON_FLUSH(1'b0), .COLLAPSE(1'b0)) u0 (
        .clk(clk), .rst(rst), .enable_bar(enable_bar), .flush(flush), .in_valid(in_valid), .in(din),
        .in_ready(u0_ready), .out(u0_out), .out_valid(u0_ov), .stage_valid(u0_sv), .occupancy(u0_occ));

    // u1: collapse and clear-on-flush with a non-zero reset value
    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hAA), .CLEAR_ON_FLUSH(1'b1), .COLLAPSE(1'b1)) u1 (
        .clk(clk), .rst(rst), .enable_bar(enable_bar), .flush(flush), .in_valid(in_valid), .in(din),
        .in_ready(u1_ready), .out(u1_out), .out_valid(u1_ov), .stage_valid(u1_sv), .occupancy(u1_occ));

    // u2: single-stage collapse
    pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .CLEAR_ON_FLUSH(1'b0), .COLLAPSE(1'b1)) u2 (
        .clk(clk), .rst(rst), .enable_bar(enable_bar), .flush(flush[0:0]), .in_valid(in_valid), .in(din),
        .in_ready(u2_ready), .out(u2_out), .out_valid(u2_ov), .stage_valid(u2_sv), .occupancy(u2_occ));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable_bar = 1'b0; in_valid = 1'b0; din = 8'd0; flush = 3'b000;
        step();
        step();
        rst = 1'b0;
    endtask

    // Leaves stage2=1, stage1=2, stage0=3, all valid.
    task automatic fill123();
        enable_bar = 1'b0; in_valid = 1'b1;
        din = 8'd1; step();
        din = 8'd2; step();
        din = 8'd3; step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (u0_out !== 8'h00 || u0_ov !== 1'b0) $display("FAIL reset_u0_out: got %h/%b expected 00/0", u0_out, u0_ov); else passed++;
        total++; if (u0_sv !== 3'b000 || u0_occ !== 2'd0) $display("FAIL reset_u0_valid: got sv=%b occ=%0d expected 000/0", u0_sv, u0_occ); else passed++;
        total++; if (u1_out !== 8'hAA || u1_ov !== 1'b0) $display("FAIL reset_u1_out: got %h/%b expected aa/0", u1_out, u1_ov); else passed++;
        total++; if (u0_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", u0_ready); else passed++;
    endtask

    task automatic test_flow();
        do_reset();
        in_valid = 1'b1;
        din = 8'd10; step();
        total++; if (u0_ov !== 1'b0 || u0_occ !== 2'd1) $display("FAIL flow_e1: got ov=%b occ=%0d expected 0/1", u0_ov, u0_occ); else passed++;
        din = 8'd11; step();
        total++; if (u0_ov !== 1'b0 || u0_occ !== 2'd2) $display("FAIL flow_e2: got ov=%b occ=%0d expected 0/2", u0_ov, u0_occ); else passed++;
        din = 8'd12; step();
        total++; if (u0_out !== 8'd10 || u0_ov !== 1'b1 || u0_occ !== 2'd3) $display("FAIL flow_e3: got %0d/%b occ=%0d expected 10/1/3", u0_out, u0_ov, u0_occ); else passed++;
        in_valid = 1'b0; step();
        total++; if (u0_out !== 8'd11 || u0_ov !== 1'b1 || u0_occ !== 2'd2) $display("FAIL flow_e4: got %0d/%b occ=%0d expected 11/1/2", u0_out, u0_ov, u0_occ); else passed++;
        step();
        total++; if (u0_out !== 8'd12 || u0_ov !== 1'b1 || u0_occ !== 2'd1) $display("FAIL flow_e5: got %0d/%b occ=%0d expected 12/1/1", u0_out, u0_ov, u0_occ); else passed++;
        step();
        total++; if (u0_ov !== 1'b0 || u0_occ !== 2'd0) $display("FAIL flow_e6: got ov=%b occ=%0d expected 0/0", u0_ov, u0_occ); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        fill123();
        enable_bar = 1'b1; in_valid = 1'b1; din = 8'd99;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (u0_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b expected 0", k, u0_ready); else passed++;
            step();
            total++; if (u0_out !== 8'd1 || u0_ov !== 1'b1 || u0_occ !== 2'd3 || u0_sv !== 3'b111) $display("FAIL stall_hold%0d: got %0d/%b occ=%0d sv=%b expected 1/1/3/111", k, u0_out, u0_ov, u0_occ, u0_sv); else passed++;
        end
        enable_bar = 1'b0; in_valid = 1'b0;
        step();
        total++; if (u0_out !== 8'd2 || u0_ov !== 1'b1) $display("FAIL stall_release1: got %0d/%b expected 2/1", u0_out, u0_ov); else passed++;
        step();
        total++; if (u0_out !== 8'd3 || u0_ov !== 1'b1) $display("FAIL stall_release2: got %0d/%b expected 3/1", u0_out, u0_ov); else passed++;
        step();
        total++; if (u0_ov !== 1'b0) $display("FAIL stall_release3: got ov=%b expected 0", u0_ov); else passed++;
    endtask

    task automatic test_collapse();
        do_reset();
        in_valid = 1'b1; din = 8'd20; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; din = 8'd21; step();
        total++; if (u1_sv !== 3'b101) $display("FAIL collapse_setup: got sv=%b expected 101", u1_sv); else passed++;
        enable_bar = 1'b1; din = 8'd127; in_valid = 1'b1;
        #1;
        total++; if (u1_ready !== 1'b1 || u0_ready !== 1'b0) $display("FAIL collapse_ready: got u1=%b u0=%b expected 1/0", u1_ready, u0_ready); else passed++;
        step();
        total++; if (u1_sv !== 3'b111 || u1_out !== 8'd20 || u1_ov !== 1'b1 || u1_occ !== 2'd3) $display("FAIL collapse_fill: got sv=%b out=%0d ov=%b occ=%0d expected 111/20/1/3", u1_sv, u1_out, u1_ov, u1_occ); else passed++;
        total++; if (u0_sv !== 3'b101 || u0_occ !== 2'd2) $display("FAIL collapse_off_hold: got sv=%b occ=%0d expected 101/2", u0_sv, u0_occ); else passed++;
        din = 8'd55;
        #1;
        total++; if (u1_ready !== 1'b0) $display("FAIL collapse_full_ready: got %b expected 0", u1_ready); else passed++;
        step();
        total++; if (u1_sv !== 3'b111 || u1_out !== 8'd20) $display("FAIL collapse_full_hold: got sv=%b out=%0d expected 111/20", u1_sv, u1_out); else passed++;
        enable_bar = 1'b0; in_valid = 1'b0;
        step();
        total++; if (u1_out !== 8'd21 || u1_ov !== 1'b1) $display("FAIL collapse_drain1: got %0d/%b expected 21/1", u1_out, u1_ov); else passed++;
        step();
        total++; if (u1_out !== 8'd127 || u1_ov !== 1'b1) $display("FAIL collapse_drain2: got %0d/%b expected 127/1", u1_out, u1_ov); else passed++;
        step();
        total++; if (u1_ov !== 1'b0) $display("FAIL collapse_drain3: got ov=%b expected 0", u1_ov); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        fill123();
        flush = 3'b010; din = 8'd5; in_valid = 1'b1;
        step();
        total++; if (u0_sv !== 3'b101 || u0_occ !== 2'd2) $display("FAIL flush_u0_sv: got sv=%b occ=%0d expected 101/2", u0_sv, u0_occ); else passed++;
        total++; if (u1_sv !== 3'b101 || u1_occ !== 2'd2) $display("FAIL flush_u1_sv: got sv=%b occ=%0d expected 101/2", u1_sv, u1_occ); else passed++;
        total++; if (u0_out !== 8'd2 || u0_ov !== 1'b1) $display("FAIL flush_out: got %0d/%b expected 2/1", u0_out, u0_ov); else passed++;
        flush = 3'b000; in_valid = 1'b0;
        step();
        total++; if (u1_out !== 8'hAA || u1_ov !== 1'b0) $display("FAIL flush_clear: got %h/%b expected aa/0", u1_out, u1_ov); else passed++;
        total++; if (u0_ov !== 1'b0) $display("FAIL flush_bubble: got ov=%b expected 0", u0_ov); else passed++;
        step();
        total++; if (u0_out !== 8'd5 || u0_ov !== 1'b1 || u1_out !== 8'd5) $display("FAIL flush_next: got u0=%0d/%b u1=%0d expected 5/1/5", u0_out, u0_ov, u1_out); else passed++;
    endtask

    task automatic test_flush_stall();
        do_reset();
        fill123();
        enable_bar = 1'b1; flush = 3'b100;
        step();
        total++; if (u0_ov !== 1'b0 || u0_sv !== 3'b011 || u0_occ !== 2'd2) $display("FAIL fstall_u0: got ov=%b sv=%b occ=%0d expected 0/011/2", u0_ov, u0_sv, u0_occ); else passed++;
        total++; if (u1_out !== 8'hAA || u1_ov !== 1'b0) $display("FAIL fstall_u1_clear: got %h/%b expected aa/0", u1_out, u1_ov); else passed++;
        flush = 3'b000; enable_bar = 1'b0;
        step();
        total++; if (u0_out !== 8'd2 || u0_ov !== 1'b1) $display("FAIL fstall_drain1: got %0d/%b expected 2/1", u0_out, u0_ov); else passed++;
        step();
        total++; if (u0_out !== 8'd3 || u0_ov !== 1'b1) $display("FAIL fstall_drain2: got %0d/%b expected 3/1", u0_out, u0_ov); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        fill123();
        enable_bar = 1'b1;
        step();
        #3;
        rst = 1'b1;
        #1;
        total++; if (u0_out !== 8'h00 || u0_ov !== 1'b0 || u0_occ !== 2'd0 || u0_sv !== 3'b000) $display("FAIL areset_u0: got %h/%b occ=%0d sv=%b expected 00/0/0/000", u0_out, u0_ov, u0_occ, u0_sv); else passed++;
        total++; if (u1_out !== 8'hAA || u1_ov !== 1'b0 || u1_occ !== 2'd0) $display("FAIL areset_u1: got %h/%b occ=%0d expected aa/0/0", u1_out, u1_ov, u1_occ); else passed++;
        #1;
        rst = 1'b0; enable_bar = 1'b0; din = 8'd77; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (u0_ov !== 1'b0) $display("FAIL areset_lat1: got ov=%b expected 0", u0_ov); else passed++;
        step();
        total++; if (u0_ov !== 1'b0) $display("FAIL areset_lat2: got ov=%b expected 0", u0_ov); else passed++;
        step();
        total++; if (u0_out !== 8'd77 || u0_ov !== 1'b1) $display("FAIL areset_lat3: got %0d/%b expected 77/1", u0_out, u0_ov); else passed++;
    endtask

    task automatic test_depth1();
        do_reset();
        enable_bar = 1'b1; din = 8'd9; in_valid = 1'b1;
        #1;
        total++; if (u2_ready !== 1'b1) $display("FAIL d1_ready_empty: got %b expected 1", u2_ready); else passed++;
        step();
        total++; if (u2_out !== 8'd9 || u2_ov !== 1'b1 || u2_occ !== 1'd1) $display("FAIL d1_load: got %0d/%b occ=%0d expected 9/1/1", u2_out, u2_ov, u2_occ); else passed++;
        din = 8'd8;
        #1;
        total++; if (u2_ready !== 1'b0) $display("FAIL d1_ready_full: got %b expected 0", u2_ready); else passed++;
        step();
        total++; if (u2_out !== 8'd9 || u2_ov !== 1'b1) $display("FAIL d1_hold: got %0d/%b expected 9/1", u2_out, u2_ov); else passed++;
        enable_bar = 1'b0;
        step();
        total++; if (u2_out !== 8'd8 || u2_ov !== 1'b1) $display("FAIL d1_advance: got %0d/%b expected 8/1", u2_out, u2_ov); else passed++;
        in_valid = 1'b0;
        step();
        total++; if (u2_ov !== 1'b0 || u2_occ !== 1'd0) $display("FAIL d1_drain: got ov=%b occ=%0d expected 0/0", u2_ov, u2_occ); else passed++;
    endtask

    initial begin
        rst = 1'b1; enable_bar = 1'b0; in_valid = 1'b0; din = 8'd0; flush = 3'b000;
        test_reset();
        test_flow();
        test_stall();
        test_collapse();
        test_flush();
        test_flush_stall();
        test_async_reset();
        test_depth1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised multi-stage pipeline register with per-stage valid tracking, global stall, per-stage flush and optional bubble collapse.
- Successor to the single-stage enable/reset flip-flop: that block becomes a DEPTH-deep, WIDTH-wide chain.
- Sits between MIPS pipeline stages (IF/ID … MEM/WB), where hazard logic drives stall and flush.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 1, number of register stages; legal range 1..16.
- RESET_VAL, 0, data value loaded on reset, and on flush when CLEAR_ON_FLUSH=1.
- CLEAR_ON_FLUSH, 0: 1 = a flushed stage's data is also forced to RESET_VAL; 0 = only its valid bit is cleared.
- COLLAPSE, 0: 1 = while stalled, stages upstream of a bubble still advance to fill it.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- enable_bar  in  1  active-low advance; 1 = downstream stall.
- flush  in  DEPTH  per-stage kill; bit i clears stage i's valid at this edge.
- in_valid  in  1  input entry valid.
- in  in  WIDTH  input data.
- in_ready  out  1  stage 0 will load at this edge (combinational).
- out  out  WIDTH  data of stage DEPTH-1.
- out_valid  out  1  valid of stage DEPTH-1.
- stage_valid  out  DEPTH  valid bits of all stages (bit 0 = entry stage).
- occupancy  out  $clog2(DEPTH+1)  registered count of valid stages.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-stall or mid-flush):
  - all data = RESET_VAL; all valid = 0; occupancy = 0.
  - out = RESET_VAL, out_valid = 0.
- Outputs are registered except in_ready; latency from in to out is DEPTH cycles when never stalled.
- Advance set A (the stages that load from their predecessor this edge):
  - enable_bar=0: A = all stages.
  - enable_bar=1, COLLAPSE=0: A = empty.
  - enable_bar=1, COLLAPSE=1: h = highest index with valid=0; A = stages 0..h; if no bubble exists, A = empty.
- in_ready = 1 iff stage 0 is in A.
- Load rule for stage i in A:
  - data_i <= data_(i-1), valid_i <= valid_(i-1).
  - stage 0 takes in and in_valid.
  - A stage not in A holds its data and valid.
- Flush, applied after the move: valid_i_next &= ~flush[i]. If CLEAR_ON_FLUSH=1, data_i_next = RESET_VAL for every flushed stage.
- Flush precedence:
  - flush overrides stall; a stalled stage with flush[i]=1 still goes invalid.
  - flush[0] with in_valid=1 and in_ready=1 drops the incoming entry.
- The entry leaving stage DEPTH-1 on an advance is consumed; there is no backpressure beyond enable_bar.
- occupancy_next = popcount(valid_next). It updates on the same edge as the valid bits and always equals popcount(stage_valid).
- Data in invalid stages is don't-care unless CLEAR_ON_FLUSH=1. Verification compares data only where valid=1.
- DEPTH=1 boundary: stage 0 is also the output stage. With COLLAPSE=1 and enable_bar=1, stage 0 loads only when it is invalid.
- Full chain with enable_bar=1 and COLLAPSE=1: in_ready=0 and input is ignored. The entry is not lost, because upstream holds whenever in_ready=0.
- Zero-width flush (flush = 0) with enable_bar=1 and COLLAPSE=0: state is bit-exact unchanged.

Decomposition:
- Shared package, pipe_pkg:
  - constant MAX_PIPE_DEPTH = 16.
  - function clog2_p1(n) for occupancy width.
  - function popcount for occupancy.
- One natural sub-module, pipe_reg_cell: one stage holding data plus valid. Inputs are load, flush and predecessor data/valid, plus the CLEAR_ON_FLUSH and RESET_VAL parameters. The top module generates DEPTH cells and computes the advance set and in_ready.

Test Plan:
- Flow: WIDTH=8, DEPTH=3, enable_bar=0; feed 10, 11, 12 (valid) on consecutive cycles -> out = 10, 11, 12 appear on cycles 3, 4, 5 with out_valid=1; occupancy peaks at 3.
- Stall: chain full {12, 11, 10}, enable_bar=1 for 4 cycles, COLLAPSE=0 -> out holds 10, occupancy 3, in_ready=0 throughout; release -> 11 appears on the next edge.
- Collapse: COLLAPSE=1, stage_valid=3'b101 (bubble at stage 1), enable_bar=1, in=8'd127, in_valid=1 -> after one edge stage_valid=3'b111, stage 2 unchanged, stage 1 = old stage 0, stage 0 = 127.
- Flush: DEPTH=3, full, flush=3'b010 with enable_bar=0 and in_valid=1, in=5 -> stage_valid=3'b101 after the edge; with CLEAR_ON_FLUSH=1 and RESET_VAL=8'hAA, stage 1 data = AA; occupancy 2.
- Flush under stall: enable_bar=1, flush=3'b100 -> out_valid=0 next edge, stages 0–1 unchanged, occupancy decrements by 1.
- Async reset: assert rst mid-cycle (not at a clock edge) while full and stalled -> out=RESET_VAL, out_valid=0 and occupancy=0 immediately, without waiting for a clock edge; deassert -> first valid input reaches out after DEPTH edges.
